// File: rtl/rs_stream_syndrome_unit.sv
`default_nettype none
// ============================================================================
// Module   : rs_stream_syndrome_unit
// Purpose  : Streaming Reed-Solomon syndrome engine. Accepts one received
//            symbol per cycle (highest-degree coefficient first) and evaluates
//            NSYN syndromes in parallel by Horner's rule over a runtime
//            programmable GF(2^SYM_W). After reset or a configuration load the
//            root table root_k = root0 * alpha^k is rebuilt over NSYN cycles
//            with a single shared multiplier before symbols are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module rs_stream_syndrome_unit #(
  parameter int               SYM_W     = 8,
  parameter int               NSYN      = 32,
  parameter logic [SYM_W:0]   DEF_POLY  = 9'h11D,
  parameter logic [SYM_W-1:0] DEF_ALPHA = 8'h02,
  parameter logic [SYM_W-1:0] DEF_ROOT0 = 8'h01,
  parameter logic [SYM_W-1:0] DEF_LEN   = 8'd255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load_i,
  input  logic [SYM_W:0]          cfg_poly_i,
  input  logic [SYM_W-1:0]        cfg_alpha_i,
  input  logic [SYM_W-1:0]        cfg_root0_i,
  input  logic [SYM_W-1:0]        cfg_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SYM_W-1:0]        in_data_i,
  input  logic                    in_last_i,
  output logic                    syn_valid_o,
  input  logic                    syn_ready_i,
  output logic [NSYN*SYM_W-1:0]   syn_data_o,
  output logic                    syn_nonzero_o,
  output logic                    syn_frame_err_o
);

  localparam int               CW        = (NSYN > 1) ? $clog2(NSYN) : 1;
  localparam logic [CW-1:0]    INIT_LAST = CW'(NSYN - 1);
  // n-1 when the programmed length is 0 (full-length code, n = 2^m-1)
  localparam logic [SYM_W-1:0] FULL_NM1  = {{(SYM_W-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // GF(2^m) multiply: shift-and-add with reduction by the field polynomial
  // at every shift, so the running multiplicand never leaves m bits.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b,
                                              input logic [SYM_W:0]   poly);
    logic [SYM_W-1:0] prod;
    logic [SYM_W:0]   sh;
    prod = '0;
    sh   = {1'b0, a};
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) prod = prod ^ sh[SYM_W-1:0];
      sh = {sh[SYM_W-1:0], 1'b0};
      if (sh[SYM_W]) sh = sh ^ poly;
    end
    return prod;
  endfunction

  state_t                  state_q;
  logic [CW-1:0]           init_cnt_q;
  logic [SYM_W-1:0]        cur_root_q;
  logic [SYM_W:0]          poly_q;
  logic [SYM_W-1:0]        alpha_q;
  logic [SYM_W-1:0]        root0_q;
  logic [SYM_W-1:0]        len_q;
  logic [SYM_W-1:0]        roots_q [NSYN];
  logic [SYM_W-1:0]        acc_q   [NSYN];
  logic [SYM_W-1:0]        acc_d   [NSYN];
  logic [SYM_W-1:0]        cnt_q;
  logic [NSYN*SYM_W-1:0]   syn_data_q;
  logic [NSYN*SYM_W-1:0]   syn_data_d;
  logic                    syn_valid_q;
  logic                    syn_nonzero_q;
  logic                    syn_frame_err_q;

  logic [SYM_W-1:0]        last_idx;
  logic                    at_end;
  logic                    accept;
  logic                    terminate;

  // One Horner step per syndrome lane; the same value is the final syndrome
  // when the current symbol terminates the block.
  generate
    for (genvar j = 0; j < NSYN; j++) begin : g_lane
      assign acc_d[j] = gf_mul(acc_q[j], roots_q[j], poly_q) ^ in_data_i;
      assign syn_data_d[j*SYM_W +: SYM_W] = acc_d[j];
    end
  endgenerate

  assign last_idx   = (len_q == '0) ? FULL_NM1 : (len_q - 1'b1);
  assign at_end     = (cnt_q == last_idx);
  assign in_ready_o = (state_q == ST_RUN) & (~syn_valid_q | syn_ready_i);
  // A handshake coinciding with a configuration load is dropped.
  assign accept     = in_valid_i & in_ready_o & ~cfg_load_i;
  assign terminate  = accept & (in_last_i | at_end);

  // Root table fill: INIT cycle k stores root_k from the shared multiplier.
  always_ff @(posedge clk) begin
    if (!rst && !cfg_load_i && (state_q == ST_INIT)) begin
      roots_q[init_cnt_q] <= cur_root_q;
    end
  end

  // Control FSM, configuration, accumulators and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_INIT;
      init_cnt_q      <= '0;
      cur_root_q      <= DEF_ROOT0;
      poly_q          <= DEF_POLY;
      alpha_q         <= DEF_ALPHA;
      root0_q         <= DEF_ROOT0;
      len_q           <= DEF_LEN;
      cnt_q           <= '0;
      syn_valid_q     <= 1'b0;
      syn_data_q      <= '0;
      syn_nonzero_q   <= 1'b0;
      syn_frame_err_q <= 1'b0;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= '0;
    end else if (cfg_load_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      cur_root_q  <= cfg_root0_i;
      poly_q      <= cfg_poly_i;
      alpha_q     <= cfg_alpha_i;
      root0_q     <= cfg_root0_i;
      len_q       <= cfg_len_i;
      cnt_q       <= '0;
      syn_valid_q <= 1'b0;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cur_root_q <= gf_mul(cur_root_q, alpha_q, poly_q);
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_q    <= ST_RUN;
            init_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (terminate) begin
            syn_data_q      <= syn_data_d;
            syn_nonzero_q   <= |syn_data_d;
            syn_frame_err_q <= in_last_i ^ at_end;
            syn_valid_q     <= 1'b1;
            cnt_q           <= '0;
            for (int j = 0; j < NSYN; j++) acc_q[j] <= '0;
          end else begin
            if (accept) begin
              cnt_q <= cnt_q + 1'b1;
              for (int j = 0; j < NSYN; j++) acc_q[j] <= acc_d[j];
            end
            if (syn_valid_q && syn_ready_i) syn_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign syn_valid_o     = syn_valid_q;
  assign syn_data_o      = syn_data_q;
  assign syn_nonzero_o   = syn_nonzero_q;
  assign syn_frame_err_o = syn_frame_err_q;

endmodule
`default_nettype wire
